gate_test_sequencer: RTL and testbench

- Controller that exhaustively exercises a small combinational gate block: drives every input pattern in turn, waits a settle window, samples the gate output and compares it against an expected truth table.
- Sits between a bench/top-level control and a gate block under test (NOT, AND, OR, XOR and similar). Replaces hand-written stimulus sequences.
- Reports pass/fail, mismatch count, first failing pattern and the captured observed truth table.

---
 rtl/gate_test_sequencer.sv | 135 +++++++++++++
 tb/tb_gate_test_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Exhaustive truth-table sequencer for a small combinational gate under test.
// Optional build macro GSEQ_STOP_ON_FAIL_EN ends a run at the first mismatch.
module gate_test_sequencer #(
    parameter int N_IN   = 1,
    parameter int SETTLE = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [2**N_IN-1:0]   expect_vec,
    input  logic                 gate_out,
    output logic [N_IN-1:0]      gate_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        fail_count,
    output logic [N_IN-1:0]      first_fail_idx,
    output logic                 first_fail_vld,
    output logic [2**N_IN-1:0]   obs_vec
);

    localparam int NPAT = 2**N_IN;
    localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] cnt;
    logic          sample;
    logic          mismatch;
    logic          last;
    logic          finish;
    logic [N_IN:0] fail_nxt;

    // gate_in doubles as the current pattern index
    assign sample   = (state == RUN) && (cnt == CW'(SETTLE - 1));
    assign mismatch = gate_out != expect_vec[gate_in];
    assign last     = gate_in == N_IN'(NPAT - 1);
    assign fail_nxt = fail_count + (N_IN + 1)'(mismatch);

`ifdef GSEQ_STOP_ON_FAIL_EN
    assign finish = last || mismatch;
`else
    assign finish = last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (sample && finish) begin
                    state_nxt = DONE;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_in        <= '0;
            cnt            <= '0;
            pass           <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
            obs_vec        <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        gate_in        <= '0;
                        cnt            <= '0;
                        pass           <= 1'b0;
                        fail_count     <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                        obs_vec        <= '0;
                    end
                end
                RUN: begin
                    if (abort) begin
                        gate_in <= '0;
                    end else if (sample) begin
                        obs_vec[gate_in] <= gate_out;
                        fail_count       <= fail_nxt;
                        if (mismatch && !first_fail_vld) begin
                            first_fail_idx <= gate_in;
                            first_fail_vld <= 1'b1;
                        end
                        if (finish) begin
                            pass <= (fail_nxt == '0);
                        end else begin
                            gate_in <= gate_in + 1'b1;
                            cnt     <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Randomized truth-table runs of gate_test_sequencer against a behavioural model.
// Follows GSEQ_STOP_ON_FAIL_EN when the build defines it.
module tb_gate_test_sequencer;

    localparam int NI = 2;
    localparam int ST = 2;
    localparam int NP = 1 << NI;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NP-1:0] expect_vec = '0;
    logic [NP-1:0] gate_tt = '0;
    logic          gate_out;
    logic [NI-1:0] gate_in;
    logic          busy;
    logic          done;
    logic          pass;
    logic [NI:0]   fail_count;
    logic [NI-1:0] first_fail_idx;
    logic          first_fail_vld;
    logic [NP-1:0] obs_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // gate under test modelled as a lookup table
    assign gate_out = gate_tt[gate_in];

    gate_test_sequencer #(.N_IN(NI), .SETTLE(ST)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .expect_vec     (expect_vec),
        .gate_out       (gate_out),
        .gate_in        (gate_in),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld),
        .obs_vec        (obs_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gate_in"}, 32'(gate_in), 0);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".pass"}, 32'(pass), 0);
        chk({tag, ".fail_count"}, 32'(fail_count), 0);
        chk({tag, ".ff_idx"}, 32'(first_fail_idx), 0);
        chk({tag, ".ff_vld"}, 32'(first_fail_vld), 0);
        chk({tag, ".obs_vec"}, 32'(obs_vec), 0);
    endtask

    task automatic run(input string tag, input logic [NP-1:0] tt,
                       input logic [NP-1:0] ev, input bit with_abort);
        logic [NP-1:0] mm;
        int nf;
        int fi;
        int len;
        int efc;
        int elast;
        int poke;
        logic [NP-1:0] eobs;
        mm = tt ^ ev;
        nf = $countones(mm);
        fi = 0;
        for (int k = NP - 1; k >= 0; k--) begin
            if (mm[k]) fi = k;
        end
        len = NP * ST;
        efc = nf;
        eobs = tt;
        elast = NP - 1;
`ifdef GSEQ_STOP_ON_FAIL_EN
        if (nf > 0) begin
            len = (fi + 1) * ST;
            efc = 1;
            eobs = tt & NP'((1 << (fi + 1)) - 1);
            elast = fi;
        end
`endif
        gate_tt = tt;
        expect_vec = ev;
        @(negedge clk);
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk({tag, ".e0_busy"}, 32'(busy), 1);
        chk({tag, ".e0_gate_in"}, 32'(gate_in), 0);
        chk({tag, ".e0_cleared"}, 32'({pass, fail_count, first_fail_vld, obs_vec}), 0);
        poke = $urandom_range(1, len - 1);
        for (int j = 1; j < len; j++) begin
            start = (j == poke);
            @(posedge clk);
            #1;
            start = 1'b0;
            chk({tag, ".run_gate_in"}, 32'(gate_in), 32'(j / ST));
            chk({tag, ".run_busy_done"}, 32'({busy, done}), 32'(2'b10));
        end
        @(posedge clk);
        #1;
        chk({tag, ".done_busy_done"}, 32'({busy, done}), 32'(2'b01));
        chk({tag, ".pass"}, 32'(pass), 32'(nf == 0));
        chk({tag, ".fail_count"}, 32'(fail_count), 32'(efc));
        chk({tag, ".ff_vld"}, 32'(first_fail_vld), 32'(nf > 0));
        chk({tag, ".ff_idx"}, 32'(first_fail_idx), 32'((nf > 0) ? fi : 0));
        chk({tag, ".obs_vec"}, 32'(obs_vec), 32'(eobs));
        chk({tag, ".last_gate_in"}, 32'(gate_in), 32'(elast));
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, ".post_busy_done"}, 32'({busy, done}), 0);
        chk({tag, ".hold_gate_in"}, 32'(gate_in), 32'(elast));
        chk({tag, ".hold_res"}, 32'({pass, fail_count, obs_vec}),
            32'({(nf == 0), (NI + 1)'(efc), eobs}));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle");

        run("and_pass", 4'b1000, 4'b1000, 1'b0);
        run("and_fail", 4'b1000, 4'b1110, 1'b0);
        run("stuck0", 4'b0000, 4'b1110, 1'b0);
        run("or_vs_and", 4'b1110, 4'b1000, 1'b0);
        run("xor_pass", 4'b0110, 4'b0110, 1'b0);
        run("all_fail", 4'b0000, 4'b1111, 1'b0);

        // abort at the first sample edge suppresses that sample
        gate_tt = 4'b1111;
        expect_vec = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk_zero("abort");
        @(posedge clk);
        #1;
        chk("abort.no_done", 32'({busy, done}), 0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_idle.busy", 32'(busy), 0);

        run("after_abort", 4'b1000, 4'b1000, 1'b0);
        run("start_wins", 4'b0110, 4'b0110, 1'b1);

        for (int r = 0; r < 24; r++) begin
            run("rand", NP'($urandom_range(0, NP * NP - 1)),
                NP'($urandom_range(0, NP * NP - 1)), 1'b0);
        end

        // asynchronous reset in the middle of a failing run
        gate_tt = 4'b1111;
        expect_vec = 4'b0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset.fail_count", 32'(fail_count), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;

        run("after_reset", 4'b1000, 4'b1000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
